nn1_argmax_classifier: RTL
==========================

Name: nn1_argmax_classifier

Overview:
- Output stage of the NN1 MNIST fully-connected network. Sits directly downstream of the ten layer-2 output neurons.
- Captures the concatenated 8-bit ReLU outputs of all classes in one valid/ready handshake, then scans them serially, one class per clk3 cycle.
- Presents the winning digit index and its score on a valid/ready result interface.
- Keeps a wrap-around count of delivered classifications for board-level debug.

Parameters:
- NUM_CLASSES, 10, number of output neurons/classes; legal range 1..16.
- output_bit, 8, width of each neuron output score (unsigned, post-ReLU).
- IDX_W, 4, width of the class index; must satisfy 2^IDX_W >= NUM_CLASSES.
- CNT_W, 16, width of the delivered-result counter.

Ports:
- clk3  input  1  single clock; all state changes on its rising edge.
- reset1  input  1  synchronous, active-low reset. Sampled on the clk3 rising edge; 0 = reset.
- in_scores  input  NUM_CLASSES*output_bit  class c score at bits [c*output_bit +: output_bit]; unsigned.
- in_valid  input  1  in_scores is valid.
- in_ready  output  1  block can accept a score vector.
- out_class  output  IDX_W  index of the winning class.
- out_score  output  output_bit  score of the winning class.
- out_all_zero  output  1  every captured score was 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result_count  output  CNT_W  number of completed result handshakes, modulo 2^CNT_W.

Behaviour:
- States: IDLE, SCAN, DONE. in_ready = (state==IDLE), combinational from state. out_valid = (state==DONE), registered.
- Reset (reset1==0 at an edge), regardless of current state or handshakes in flight:
  - state=IDLE, out_class=0, out_score=0, out_all_zero=0, out_valid=0, result_count=0.
  - Internal score buffer, scan index and best registers cleared.
  - An in-progress scan is abandoned and no result is produced.
- IDLE, on in_valid=1 (in_ready=1):
  - latch in_scores into the internal buffer;
  - best_val=score[0], best_idx=0, nz=(score[0]!=0), scan_idx=1;
  - next state SCAN, or DONE directly if NUM_CLASSES==1.
- IDLE, in_valid=0: hold all state.
- SCAN, each cycle: compare buffer score[scan_idx] with best_val as unsigned values.
  - Strictly greater: best_val, best_idx update. Ties keep the lower index.
  - nz |= (score[scan_idx]!=0). scan_idx increments.
  - When the cycle processes scan_idx==NUM_CLASSES-1:
    - next state DONE;
    - out_class/out_score load the final best, including that last comparison;
    - out_all_zero = ~nz.
- Latency: a vector accepted at edge k gives out_valid=1 after edge k+NUM_CLASSES-1, i.e. 9 cycles for the default.
- in_scores and in_valid are ignored outside IDLE. The input buffer isolates the scan from upstream changes.
- DONE:
  - out_valid=1; out_class, out_score and out_all_zero are held stable.
  - On out_ready=1 at an edge: state=IDLE, out_valid=0, result_count increments, wrapping from 2^CNT_W-1 to 0.
  - Output data registers keep their last value after the handshake.
- No pass-through or overlap: a new vector is accepted at the earliest one cycle after the result handshake. in_ready is 0 in the DONE cycle even if out_ready=1.
- out_ready held high before DONE has no effect.
- All-zero input (the typical case when every neuron is clamped by ReLU): out_class=0, out_score=0, out_all_zero=1.

Test Plan:
- Reset, then scores {c0..c9} = {3,7,1,0,12,5,12,2,0,9}, in_valid pulse, out_ready=1 -> in_ready drops the next cycle; out_valid rises 9 cycles after acceptance; out_class=4, out_score=12, out_all_zero=0; tie with class 6 resolved to the lower index; result_count=1.
- All ten scores = 0 -> out_class=0, out_score=0, out_all_zero=1. Scores with only c9=255 -> out_class=9, out_score=255.
- Back-pressure: out_ready held 0 for 20 cycles after out_valid -> outputs stable and in_ready=0 throughout; in_valid pulses meanwhile are ignored. Raising out_ready -> one handshake, IDLE the next cycle.
- Drive in_scores to new values during SCAN (changed after acceptance, not re-sampled) -> result reflects only the vector captured at acceptance.
- Assert reset1=0 for one cycle at scan cycle 4 -> no out_valid, all outputs 0, result_count=0, in_ready=1 the next cycle. A following vector classifies correctly.
- Set CNT_W=4 and run 17 back-to-back classifications -> result_count reaches 15, wraps to 0, then 1.

Source files
------------

// File: rtl/nn1_argmax_classifier.sv
// nn1_argmax_classifier
// Output stage of the NN1 fully-connected network. Captures all class scores
// in one handshake, scans them one class per clock to find the arg-max
// (ties keep the lower index), then presents the result on a valid/ready
// interface. A wrap-around counter tracks delivered results.
module nn1_argmax_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int output_bit  = 8,
  parameter int IDX_W       = 4,
  parameter int CNT_W       = 16
) (
  input  logic                              clk3,
  input  logic                              reset1,
  input  logic [NUM_CLASSES*output_bit-1:0] in_scores,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [IDX_W-1:0]                  out_class,
  output logic [output_bit-1:0]             out_score,
  output logic                              out_all_zero,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [CNT_W-1:0]                  result_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CLASSES - 1);

  logic [1:0]                        state;
  logic [NUM_CLASSES*output_bit-1:0] score_buf;
  logic [IDX_W-1:0]                  scan_idx;
  logic [output_bit-1:0]             best_val;
  logic [IDX_W-1:0]                  best_idx;
  logic                              nz;

  logic [output_bit-1:0]             cur_score;
  logic [output_bit-1:0]             next_best_val;
  logic [IDX_W-1:0]                  next_best_idx;
  logic                              next_nz;

  // Strictly-greater test; equal scores never displace the earlier class.
  function automatic logic beats(input logic [output_bit-1:0] cand,
                                 input logic [output_bit-1:0] best);
    return cand > best;
  endfunction

  assign in_ready = (state == IDLE);

  // Select the buffered score addressed by the scan index and fold it into the running best.
  always_comb begin
    cur_score = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (scan_idx == IDX_W'(c)) begin
        cur_score = score_buf[c*output_bit +: output_bit];
      end
    end
    next_best_val = best_val;
    next_best_idx = best_idx;
    if (beats(cur_score, best_val)) begin
      next_best_val = cur_score;
      next_best_idx = scan_idx;
    end
    next_nz = nz | (cur_score != '0);
  end

  // Control FSM plus capture buffer, scan registers, result registers and counter.
  always_ff @(posedge clk3) begin
    if (!reset1) begin
      state        <= IDLE;
      score_buf    <= '0;
      scan_idx     <= '0;
      best_val     <= '0;
      best_idx     <= '0;
      nz           <= 1'b0;
      out_class    <= '0;
      out_score    <= '0;
      out_all_zero <= 1'b0;
      out_valid    <= 1'b0;
      result_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            score_buf <= in_scores;
            best_val  <= in_scores[output_bit-1:0];
            best_idx  <= '0;
            nz        <= (in_scores[output_bit-1:0] != '0);
            scan_idx  <= IDX_W'(1);
            if (NUM_CLASSES == 1) begin
              // A single class is trivially the winner; skip the scan.
              state        <= DONE;
              out_valid    <= 1'b1;
              out_class    <= '0;
              out_score    <= in_scores[output_bit-1:0];
              out_all_zero <= (in_scores[output_bit-1:0] == '0);
            end else begin
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          best_val <= next_best_val;
          best_idx <= next_best_idx;
          nz       <= next_nz;
          scan_idx <= scan_idx + IDX_W'(1);
          if (scan_idx == IDX_LAST) begin
            state        <= DONE;
            out_valid    <= 1'b1;
            out_class    <= next_best_idx;
            out_score    <= next_best_val;
            out_all_zero <= ~next_nz;
          end
        end
        DONE: begin
          if (out_ready) begin
            state        <= IDLE;
            out_valid    <= 1'b0;
            result_count <= result_count + CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
